// File: rtl/crc16_frame_ctrl.sv
// Byte-stream frame sequencer around a 2-bit/cycle CRC-16 core (poly 0x8005, init 0xFFFF).
// GEN mode appends the CRC MSB byte first; CHECK mode reports whether the residual reached zero.
module crc16_core2 (
  input  logic        clk,
  input  logic        crc_rst,
  input  logic        crc_en,
  input  logic [1:0]  data_in,
  output logic [15:0] crc_q
);
  logic [15:0] crc_d;

  function automatic logic [15:0] step(input logic [15:0] c, input logic b);
    return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h8005 : 16'h0000);
  endfunction

  // data_in[1] is the earlier (more significant) bit of the pair
  always_comb crc_d = crc_en ? step(step(crc_q, data_in[1]), data_in[0]) : crc_q;

  always_ff @(posedge clk or posedge crc_rst) begin
    if (crc_rst) crc_q <= 16'hFFFF;
    else         crc_q <= crc_d;
  end
endmodule

module crc16_frame_ctrl #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [7:0]       m_data,
  output logic             m_last,
  output logic             done,
  output logic             crc_ok,
  output logic [15:0]      crc_value,
  output logic [LEN_W-1:0] len_out,
  output logic             len_err
);
  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_WAIT, S_SHIFT, S_SEND, S_APP_HI, S_APP_LO, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic               init_q, init_d;
  logic               mode_q, mode_d;
  logic [7:0]         shreg_q, shreg_d;
  logic [7:0]         byte_q, byte_d;
  logic               last_q, last_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [LEN_W-1:0]   len_q, len_d, len_inc;
  logic               len_err_q, len_err_d;
  logic               crc_ok_q, crc_ok_d;
  logic               crc_en;
  logic               crc_rst;

  // init_q is a flop output, so the core reset pulse is glitch-free
  assign crc_rst = rst | init_q;

  crc16_core2 u_core (
    .clk     (clk),
    .crc_rst (crc_rst),
    .crc_en  (crc_en),
    .data_in (shreg_q[7:6]),
    .crc_q   (crc_value)
  );

  assign len_inc = len_q + 1'b1;
  assign len_out = len_q;
  assign len_err = len_err_q;
  assign crc_ok  = crc_ok_q;

  always_comb begin
    state_d   = state_q;
    init_d    = 1'b0;
    mode_d    = mode_q;
    shreg_d   = shreg_q;
    byte_d    = byte_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    len_err_d = len_err_q;
    crc_ok_d  = crc_ok_q;
    crc_en    = 1'b0;
    s_ready   = 1'b0;
    m_valid   = 1'b0;
    m_data    = 8'h00;
    m_last    = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d    = mode;
          len_d     = '0;
          len_err_d = 1'b0;
          crc_ok_d  = 1'b0;
          init_d    = 1'b1;
          state_d   = S_INIT;
        end
      end
      S_INIT: state_d = S_WAIT;
      S_WAIT: begin
        s_ready = 1'b1;
        if (s_valid) begin
          shreg_d = s_data;
          byte_d  = s_data;
          last_d  = s_last;
          len_d   = len_inc;
          cnt_d   = 2'd0;
          if (len_inc == '0) len_err_d = 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        crc_en  = 1'b1;
        shreg_d = {shreg_q[5:0], 2'b00};
        cnt_d   = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = S_SEND;
      end
      S_SEND: begin
        m_valid = 1'b1;
        m_data  = byte_q;
        m_last  = last_q & mode_q;
        if (m_ready) begin
          if (!last_q)     state_d = S_WAIT;
          else if (mode_q) state_d = S_DONE;
          else             state_d = S_APP_HI;
        end
      end
      S_APP_HI: begin
        m_valid = 1'b1;
        m_data  = crc_value[15:8];
        if (m_ready) state_d = S_APP_LO;
      end
      S_APP_LO: begin
        m_valid = 1'b1;
        m_data  = crc_value[7:0];
        m_last  = 1'b1;
        if (m_ready) state_d = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        crc_ok_d = mode_q & (crc_value == 16'h0000);
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      init_q    <= 1'b0;
      mode_q    <= 1'b0;
      shreg_q   <= 8'h00;
      byte_q    <= 8'h00;
      last_q    <= 1'b0;
      cnt_q     <= 2'd0;
      len_q     <= '0;
      len_err_q <= 1'b0;
      crc_ok_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      init_q    <= init_d;
      mode_q    <= mode_d;
      shreg_q   <= shreg_d;
      byte_q    <= byte_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      len_err_q <= len_err_d;
      crc_ok_q  <= crc_ok_d;
    end
  end
endmodule

// File: tb/tb_crc16_frame_ctrl.sv
// Scoreboard bench for crc16_frame_ctrl: driver pushes expected bytes/done results, monitor pops on handshakes.
module tb_crc16_frame_ctrl;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, start2 = 1'b0, mode = 1'b0;
  logic        s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b1, m_ready2 = 1'b1;
  logic [7:0]  s_data = 8'h00;
  logic        s_ready, m_valid, m_last, done, crc_ok, len_err;
  logic [7:0]  m_data;
  logic [15:0] crc_value, len_out;
  logic        s_ready2, m_valid2, m_last2, done2, crc_ok2, len_err2;
  logic [7:0]  m_data2;
  logic [15:0] crc_value2;
  logic [1:0]  len_out2;

  crc16_frame_ctrl #(.LEN_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .done(done), .crc_ok(crc_ok), .crc_value(crc_value), .len_out(len_out), .len_err(len_err)
  );

  crc16_frame_ctrl #(.LEN_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .mode(mode),
    .s_valid(s_valid), .s_ready(s_ready2), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid2), .m_ready(m_ready2), .m_data(m_data2), .m_last(m_last2),
    .done(done2), .crc_ok(crc_ok2), .crc_value(crc_value2), .len_out(len_out2), .len_err(len_err2)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  logic [8:0]  exp_q[$];
  logic [16:0] exp_done[$];
  logic [7:0]  cap_q[$];
  logic        pend = 1'b0;
  logic [16:0] pend_v;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: bit-serial MSB-first CRC over whole bytes
  function automatic logic [15:0] crc_model(input logic [7:0] fr[$]);
    logic [15:0] c = 16'hFFFF;
    logic fb;
    for (int i = 0; i < fr.size(); i++)
      for (int k = 7; k >= 0; k--) begin
        fb = c[15] ^ fr[i][k];
        c  = c << 1;
        if (fb) c = c ^ 16'h8005;
      end
    return c;
  endfunction

  always @(negedge clk) begin
    if (pend) begin
      pend = 1'b0;
      chk("crc_ok", crc_ok, pend_v[16]);
      chk("len_out", len_out, pend_v[15:0]);
    end
    if (!rst && m_valid && m_ready) begin
      cap_q.push_back(m_data);
      if (exp_q.size() == 0) chk("unexpected_byte", 1, 0);
      else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        chk("m_data", m_data, e[7:0]);
        chk("m_last", m_last, e[8]);
      end
    end
    if (!rst && done) begin
      if (exp_done.size() == 0) chk("spurious_done", 1, 0);
      else begin
        pend_v = exp_done.pop_front();
        pend   = 1'b1;
      end
    end
  end

  task automatic push_exp(input logic md, input logic [7:0] fr[$], input logic ok);
    logic [15:0] c;
    for (int i = 0; i < fr.size(); i++)
      exp_q.push_back({md && (i == fr.size() - 1), fr[i]});
    if (!md) begin
      c = crc_model(fr);
      exp_q.push_back({1'b0, c[15:8]});
      exp_q.push_back({1'b1, c[7:0]});
    end
    exp_done.push_back({ok, 16'(fr.size())});
  endtask

  task automatic start_frame(input logic md);
    @(posedge clk); #1 mode = md; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic feed(input logic [7:0] fr[$], input bit two, input bit mark_last);
    for (int i = 0; i < fr.size(); i++) begin
      int t = 0;
      bit got = 0;
      s_valid = 1'b1; s_data = fr[i]; s_last = mark_last && (i == fr.size() - 1);
      while (!got && t < 500) begin
        @(negedge clk);
        if (two ? s_ready2 : s_ready) got = 1;
        t++;
      end
      if (!got) chk("accept_timeout", 0, 1);
      @(posedge clk); #1 s_valid = 1'b0; s_last = 1'b0;
      if (two) begin
        @(negedge clk);
        chk("len_err_w2", len_err2, (i >= 3));
      end
    end
  endtask

  task automatic wait_done();
    int t = 0;
    while ((exp_done.size() != 0 || pend) && t < 3000) begin
      @(negedge clk); t++;
    end
    if (t >= 3000) chk("done_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic wait_mvalid();
    int t = 0;
    while (!m_valid && t < 100) begin
      @(negedge clk); t++;
    end
    if (!m_valid) chk("m_valid_timeout", 0, 1);
  endtask

  task automatic run_frame(input logic md, input logic [7:0] fr[$], input logic ok);
    push_exp(md, fr, ok);
    start_frame(md);
    feed(fr, 0, 1);
    wait_done();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0]  fr[$], fr2[$];
    logic [15:0] c;
    int t;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_done", done, 0);
    chk("rst_crc_ok", crc_ok, 0);
    chk("rst_len_out", len_out, 0);
    chk("rst_len_err", len_err, 0);
    chk("rst_crc", crc_value, 16'hFFFF);
    @(posedge clk); #1 rst = 1'b0;

    // GEN {FF,FF}: CRC register ends at 0000
    fr = '{8'hFF, 8'hFF};
    exp_q.push_back({1'b0, 8'hFF}); exp_q.push_back({1'b0, 8'hFF});
    exp_q.push_back({1'b0, 8'h00}); exp_q.push_back({1'b1, 8'h00});
    exp_done.push_back({1'b0, 16'd2});
    start_frame(1'b0); feed(fr, 0, 1); wait_done();
    chk("gen_ffff_crc", crc_value, 16'h0000);

    run_frame(1'b1, fr, 1'b1);
    fr = '{8'hFF, 8'hFE};
    run_frame(1'b1, fr, 1'b0);
    chk("chk_fffe_crc", crc_value, 16'h8005);

    // Backpressure on SEND and APP_HI
    fr = '{8'hA5};
    c  = crc_model(fr);
    push_exp(1'b0, fr, 1'b0);
    m_ready = 1'b0;
    start_frame(1'b0); feed(fr, 0, 1);
    wait_mvalid();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_send_data", m_data, 8'hA5);
      chk("bp_send_last", m_last, 0);
      chk("bp_send_srdy", s_ready, 0);
      chk("bp_send_crc", crc_value, c);
    end
    @(posedge clk); #1 m_ready = 1'b1;
    @(posedge clk); #1 m_ready = 1'b0;
    wait_mvalid();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hi_data", m_data, c[15:8]);
      chk("bp_hi_last", m_last, 0);
      chk("bp_hi_srdy", s_ready, 0);
    end
    @(posedge clk); #1 m_ready = 1'b1;
    wait_done();

    // Abort with rst while byte 3 is shifting
    exp_q.push_back({1'b0, 8'h11}); exp_q.push_back({1'b0, 8'h22});
    start_frame(1'b0);
    fr = '{8'h11, 8'h22, 8'h33};
    feed(fr, 0, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("abort_s_ready", s_ready, 0);
    chk("abort_m_valid", m_valid, 0);
    chk("abort_len_out", len_out, 0);
    chk("abort_crc", crc_value, 16'hFFFF);
    @(posedge clk); #1 rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort_no_byte", exp_q.size(), 0);
    fr = '{8'hFF, 8'hFF};
    exp_q.push_back({1'b0, 8'hFF}); exp_q.push_back({1'b0, 8'hFF});
    exp_q.push_back({1'b0, 8'h00}); exp_q.push_back({1'b1, 8'h00});
    exp_done.push_back({1'b0, 16'd2});
    start_frame(1'b0); feed(fr, 0, 1); wait_done();

    // GEN output looped back through CHECK
    for (int f = 0; f < 3; f++) begin
      int n;
      n = (f == 0) ? 1 : $urandom_range(2, 64);
      fr.delete();
      for (int i = 0; i < n; i++) fr.push_back(8'($urandom));
      cap_q.delete();
      run_frame(1'b0, fr, 1'b0);
      chk("loop_len", cap_q.size(), n + 2);
      fr2 = cap_q;
      run_frame(1'b1, fr2, 1'b1);
    end

    // LEN_W=2 instance: 5-byte frame wraps the counter
    @(posedge clk); #1 mode = 1'b0; start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    fr = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    feed(fr, 1, 1);
    t = 0;
    while (!done2 && t < 200) begin
      @(negedge clk); t++;
    end
    chk("w2_done_seen", done2, 1);
    @(negedge clk);
    chk("w2_len_out", len_out2, 2'd1);
    chk("w2_len_err", len_err2, 1);

    chk("exp_q_empty", exp_q.size(), 0);
    chk("exp_done_empty", exp_done.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
